core_seq: RTL and testbench
===========================

// Module: core_seq
// PURPOSE
//  Multi-cycle execution sequencer for the RV32 core; successor to the single-cycle top where PC/GPR/CSR write every clock.
//  Drives the PC, fetch and load/store over valid/ready handshakes, and issues one-cycle commit strobes.
//  Datapath (IDU, CSG, ALU, BranchCond, GPR, CSR) stays combinational around it; this block owns only sequencing and timing.
// PARAMETERS
//  XLEN      32            PC/address width
//  RESET_PC  32'h80000000  PC value loaded on reset
//  TIMEOUT   255           max wait cycles for any response before bus error (>=1)
// PORTS
//  clk            in   1     clock, all state updates on posedge
//  rst            in   1     reset, asynchronous assert, active-low (0 = reset)
//  pc             out  XLEN  current PC
//  inst           out  32    latched instruction, valid from EXEC until next fetch
//  next_pc        in   XLEN  branch-unit result for the current inst
//  ifu_req_valid  out  1     fetch request; address = pc
//  ifu_req_ready  in   1     fetch request accepted
//  ifu_rsp_valid  in   1     fetch data valid
//  ifu_rsp_data   in   32    fetched instruction
//  ifu_rsp_err    in   1     fetch bus error, qualified by ifu_rsp_valid
//  mem_rd_en      in   1     decoded: inst is a load
//  mem_wr_en      in   1     decoded: inst is a store
//  lsu_req_valid  out  1     load/store request (addr/data from datapath)
//  lsu_req_ready  in   1     load/store request accepted
//  lsu_rsp_valid  in   1     load data / store ack valid
//  lsu_rsp_err    in   1     load/store bus error, qualified by lsu_rsp_valid
//  gpr_wr_en      in   1     decoded GPR write enable
//  csr_wr_en      in   1     decoded CSR write enable
//  ebreak         in   1     decoded ebreak
//  trap_vec       in   XLEN  trap target (mtvec)
//  gpr_commit     out  1     one-cycle GPR write strobe
//  csr_commit     out  1     one-cycle CSR write strobe
//  retire         out  1     one-cycle pulse per completed instruction
//  halted         out  1     sticky; core stopped
//  bus_err        out  1     one-cycle pulse on error/timeout
// BEHAVIOUR
//  States: FETCH -> FWAIT -> EXEC -> [MREQ -> MWAIT] -> WB -> FETCH; HALT terminal.
//  Reset (rst=0, async): state=FETCH, pc=RESET_PC, inst=0, all strobes/valids=0, halted=0, wait counter=0.
//  FETCH: ifu_req_valid=1, held with pc stable until ifu_req_ready; handshake -> FWAIT.
//  FWAIT: ifu_rsp_valid (no earlier than cycle after request handshake) latches inst -> EXEC.
//  EXEC: one cycle, datapath settles. ebreak -> HALT (halted=1, retire=1 that cycle).
//    mem_rd_en|mem_wr_en -> MREQ; else -> WB. Both enables high: treated as load.
//  MREQ: lsu_req_valid=1 until lsu_req_ready -> MWAIT. MWAIT: lsu_rsp_valid -> WB.
//  WB: gpr_commit=gpr_wr_en (0 for stores), csr_commit=csr_wr_en, retire=1, pc<=next_pc -> FETCH.
//  Min latency: 4 cycles/inst (FETCH,FWAIT,EXEC,WB) with zero-wait bus; loads/stores +2.
//  Wait counter: cleared on entering FWAIT/MWAIT, +1 per cycle while response absent; at TIMEOUT -> bus error.
//  Request-phase stalls (ready low) are unbounded; timeout covers response phase only.
//  rsp_valid with err=1 -> bus error; response data ignored, no commit strobes.
//  rsp_valid in the cycle counter hits TIMEOUT: response wins, no error.
//  Stray rsp_valid outside its WAIT state: ignored.
//  HALT: all valids and strobes 0, pc frozen; exits only via reset.
//  Reset mid-transaction: request dropped immediately; interconnect must tolerate abandoned valid.
//  pc arithmetic modulo 2^XLEN; no alignment check here.
// CONFIGURATION
//  BUS_ERR_TRAP_EN defined: bus error -> bus_err=1 one cycle, pc<=trap_vec, no retire/commit, state -> FETCH.
//  BUS_ERR_TRAP_EN undefined: bus error -> bus_err=1 one cycle, state -> HALT, halted=1, pc frozen at faulting inst.
// TESTING
//  Reset release, ready/rsp tied 1, addi stream -> first fetch addr 0x80000000, retire every 4th cycle, pc +4.
//  ifu_req_ready low 10 cycles -> ifu_req_valid and pc held stable, no timeout, fetch completes.
//  Load with lsu_rsp after 3 cycles -> gpr_commit exactly once, 9 cycles fetch-to-retire.
//  No lsu_rsp, TIMEOUT=8 -> bus_err after 8 wait cycles; trap to trap_vec=0x80001000 (macro) or halted=1 (no macro).
//  ebreak at 0x80000010 -> retire pulse, halted=1, pc stays 0x80000010, no further ifu_req_valid.
//  rst low during MWAIT -> next cycle pc=0x80000000, lsu_req_valid=0, state FETCH.

Source files
------------

// File: rtl/core_seq.sv
`default_nettype none
// ============================================================================
// Module   : core_seq
// Purpose  : Multi-cycle RV32 execution sequencer. It steps PC, fetch and
//            load/store through valid/ready handshakes, and issues one-cycle
//            commit, retire and bus-error strobes. Define BUS_ERR_TRAP_EN to
//            redirect to trap_vec_i on a bus error instead of halting.
// Revision : 1.0  initial release
// ============================================================================
module core_seq #(
  parameter int unsigned         XLEN     = 32,
  parameter logic [XLEN-1:0]     RESET_PC = 'h8000_0000,
  parameter int unsigned         TIMEOUT  = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     inst_o,
  input  logic [XLEN-1:0] next_pc_i,
  output logic            ifu_req_valid_o,
  input  logic            ifu_req_ready_i,
  input  logic            ifu_rsp_valid_i,
  input  logic [31:0]     ifu_rsp_data_i,
  input  logic            ifu_rsp_err_i,
  input  logic            mem_rd_en_i,
  input  logic            mem_wr_en_i,
  output logic            lsu_req_valid_o,
  input  logic            lsu_req_ready_i,
  input  logic            lsu_rsp_valid_i,
  input  logic            lsu_rsp_err_i,
  input  logic            gpr_wr_en_i,
  input  logic            csr_wr_en_i,
  input  logic            ebreak_i,
  input  logic [XLEN-1:0] trap_vec_i,
  output logic            gpr_commit_o,
  output logic            csr_commit_o,
  output logic            retire_o,
  output logic            halted_o,
  output logic            bus_err_o
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_FWAIT = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MREQ  = 3'd3;
  localparam logic [2:0] S_MWAIT = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;

  localparam int unsigned    CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            w_bus_err;
  logic            w_store;

  // A response on the last permitted wait cycle wins over the timeout.
  always_comb begin
    w_bus_err = 1'b0;
    if (state_q == S_FWAIT) begin
      w_bus_err = ifu_rsp_valid_i ? ifu_rsp_err_i : (cnt_q == CNT_LAST);
    end else if (state_q == S_MWAIT) begin
      w_bus_err = lsu_rsp_valid_i ? lsu_rsp_err_i : (cnt_q == CNT_LAST);
    end
  end

  assign w_store = mem_wr_en_i & ~mem_rd_en_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH: begin
        if (ifu_req_ready_i) begin
          state_d = S_FWAIT;
          cnt_d   = '0;
        end
      end
      S_FWAIT: begin
        if (ifu_rsp_valid_i) begin
          if (!ifu_rsp_err_i) begin
            inst_d  = ifu_rsp_data_i;
            state_d = S_EXEC;
          end
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        if (ebreak_i) begin
          state_d = S_HALT;
        end else if (mem_rd_en_i || mem_wr_en_i) begin
          state_d = S_MREQ;
        end else begin
          state_d = S_WB;
        end
      end
      S_MREQ: begin
        if (lsu_req_ready_i) begin
          state_d = S_MWAIT;
          cnt_d   = '0;
        end
      end
      S_MWAIT: begin
        if (lsu_rsp_valid_i) begin
          if (!lsu_rsp_err_i) begin
            state_d = S_WB;
          end
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        pc_d    = next_pc_i;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    if (w_bus_err) begin
`ifdef BUS_ERR_TRAP_EN
      state_d = S_FETCH;
      pc_d    = trap_vec_i;
`else
      state_d = S_HALT;
`endif
    end
  end

`ifndef BUS_ERR_TRAP_EN
  logic w_unused_trap_vec;
  assign w_unused_trap_vec = ^trap_vec_i;
`endif

  // Request valids are masked while reset is held so nothing is offered.
  always_comb begin
    ifu_req_valid_o = rst_ni && (state_q == S_FETCH);
    lsu_req_valid_o = rst_ni && (state_q == S_MREQ);
    gpr_commit_o    = (state_q == S_WB) && gpr_wr_en_i && !w_store;
    csr_commit_o    = (state_q == S_WB) && csr_wr_en_i;
    retire_o        = (state_q == S_WB) || ((state_q == S_EXEC) && ebreak_i);
    halted_o        = (state_q == S_HALT) || ((state_q == S_EXEC) && ebreak_i);
    bus_err_o       = w_bus_err;
    pc_o            = pc_q;
    inst_o          = inst_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_core_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_seq
// Purpose  : Self-checking bench for core_seq; the bench plays the fetch and
//            load/store buses from a per-instruction timing plan.
// Revision : 1.0  initial release
// ============================================================================
module tb_core_seq;

  localparam int          TMO      = 8;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] TRAP     = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, inst, next_pc, trap_vec, ifu_rsp_data;
  logic ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic mem_rd_en, mem_wr_en, lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
  logic gpr_wr_en, csr_wr_en, ebreak, gpr_commit, csr_commit, retire, halted, bus_err;

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] m_pc;

  core_seq #(.XLEN(32), .RESET_PC(RESET_PC), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pc_o(pc), .inst_o(inst), .next_pc_i(next_pc),
    .ifu_req_valid_o(ifu_req_valid), .ifu_req_ready_i(ifu_req_ready),
    .ifu_rsp_valid_i(ifu_rsp_valid), .ifu_rsp_data_i(ifu_rsp_data), .ifu_rsp_err_i(ifu_rsp_err),
    .mem_rd_en_i(mem_rd_en), .mem_wr_en_i(mem_wr_en),
    .lsu_req_valid_o(lsu_req_valid), .lsu_req_ready_i(lsu_req_ready),
    .lsu_rsp_valid_i(lsu_rsp_valid), .lsu_rsp_err_i(lsu_rsp_err),
    .gpr_wr_en_i(gpr_wr_en), .csr_wr_en_i(csr_wr_en), .ebreak_i(ebreak), .trap_vec_i(trap_vec),
    .gpr_commit_o(gpr_commit), .csr_commit_o(csr_commit), .retire_o(retire),
    .halted_o(halted), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rand_bus();
    ifu_req_ready = 1'($urandom);
    ifu_rsp_valid = 1'($urandom);
    ifu_rsp_err   = 1'($urandom);
    ifu_rsp_data  = $urandom;
    lsu_req_ready = 1'($urandom);
    lsu_rsp_valid = 1'($urandom);
    lsu_rsp_err   = 1'($urandom);
  endtask

  task automatic do_reset();
    ifu_req_ready = 0; ifu_rsp_valid = 0; lsu_req_ready = 0; lsu_rsp_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, RESET_PC);
    chk("rst_inst", inst, 32'h0);
    chk("rst_ifv", {31'b0, ifu_req_valid}, 32'h0);
    chk("rst_lsv", {31'b0, lsu_req_valid}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_retire", {31'b0, retire}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_pc  = RESET_PC;
  endtask

  // Terminal state: nothing requested or committed whatever the bus does.
  task automatic halt_check();
    for (int i = 0; i < 6; i++) begin
      rand_bus();
      @(negedge clk);
      chk("halt_halted", {31'b0, halted}, 32'h1);
      chk("halt_ifv", {31'b0, ifu_req_valid}, 32'h0);
      chk("halt_lsv", {31'b0, lsu_req_valid}, 32'h0);
      chk("halt_retire", {31'b0, retire}, 32'h0);
      chk("halt_commit", {30'b0, gpr_commit, csr_commit}, 32'h0);
      chk("halt_pc", pc, m_pc);
      @(posedge clk); #1;
    end
  endtask

  // kind: 0 alu, 1 csr, 2 load, 3 store, 4 load+store, 5 ebreak
  // a: fetch-ready delay, b: fetch-rsp delay, m: lsu-ready delay, n: lsu-rsp delay
  // term: 0 ok, 1 error response, 2 no response (timeout)
  task automatic do_inst(input int kind, input int a, input int b_in, input int fterm,
                         input int m, input int n_in, input int lterm, input bit seq,
                         input bit abort);
    int b, n, fwl, e, mr0, mrl, mw0, mwl, w, last, rst_at;
    bit is_mem, is_ebk, exp_gpr, ferr, lerr, anyerr, okret;
    logic [31:0] np, fdata;
    b      = (fterm == 2) ? TMO - 1 : b_in;
    n      = (lterm == 2) ? TMO - 1 : n_in;
    is_ebk = (kind == 5);
    is_mem = (kind >= 2 && kind <= 4);
    fwl = a + 1 + b;
    e   = fwl + 1;
    mr0 = e + 1; mrl = e + 1 + m; mw0 = mrl + 1; mwl = mw0 + n;
    if (!is_mem) begin mr0 = -1; mrl = -1; mw0 = -1; mwl = -1; end
    w      = is_mem ? mwl + 1 : e + 1;
    ferr   = (fterm != 0);
    lerr   = is_mem && !ferr && (lterm != 0);
    anyerr = ferr || lerr;
    last   = ferr ? fwl : (is_ebk ? e : (lerr ? mwl : w));
    rst_at = abort ? mw0 + 1 : -1;
    okret  = !anyerr && !is_ebk;
    exp_gpr = !is_ebk && (kind != 3);
    np = seq ? m_pc + 32'd4 : $urandom;
    if (!seq) np[1:0] = 2'b00;
    fdata = $urandom;
    mem_rd_en = (kind == 2 || kind == 4);
    mem_wr_en = (kind == 3 || kind == 4);
    gpr_wr_en = !is_ebk;
    csr_wr_en = (kind == 1);
    ebreak    = is_ebk;
    next_pc   = np;
    trap_vec  = TRAP;
    for (int c = 0; c <= last; c++) begin
      rand_bus();
      if (c <= a) ifu_req_ready = (c == a);
      if (c > a && c <= fwl) begin
        ifu_rsp_valid = (c == fwl) && (fterm != 2);
        ifu_rsp_err   = (fterm == 1);
        ifu_rsp_data  = fdata;
      end
      if (c >= mr0 && c <= mrl) lsu_req_ready = (c == mrl);
      if (c >= mw0 && c <= mwl) begin
        lsu_rsp_valid = (c == mwl) && (lterm != 2);
        lsu_rsp_err   = (lterm == 1);
      end
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_pc", pc, RESET_PC);
        chk("abort_lsv", {31'b0, lsu_req_valid}, 32'h0);
        chk("abort_ifv", {31'b0, ifu_req_valid}, 32'h0);
        chk("abort_inst", inst, 32'h0);
        break;
      end
      @(negedge clk);
      chk("ifu_req_valid", {31'b0, ifu_req_valid}, {31'b0, c <= a});
      chk("lsu_req_valid", {31'b0, lsu_req_valid}, {31'b0, c >= mr0 && c <= mrl});
      chk("retire", {31'b0, retire},
          {31'b0, (c == e && is_ebk && !ferr) || (c == w && okret)});
      chk("halted", {31'b0, halted}, {31'b0, c == e && is_ebk && !ferr});
      chk("gpr_commit", {31'b0, gpr_commit}, {31'b0, c == w && okret && exp_gpr});
      chk("csr_commit", {31'b0, csr_commit}, {31'b0, c == w && okret && kind == 1});
      chk("bus_err", {31'b0, bus_err}, {31'b0, c == last && anyerr});
      chk("pc", pc, m_pc);
      if (c >= e && !ferr) chk("inst", inst, fdata);
      @(posedge clk); #1;
    end
    if (abort) begin
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_pc  = RESET_PC;
    end else if (anyerr) begin
`ifdef BUS_ERR_TRAP_EN
      m_pc = TRAP;
`else
      halt_check();
      do_reset();
`endif
    end else if (is_ebk) begin
      halt_check();
      do_reset();
    end else begin
      m_pc = np;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_err = 0; ifu_rsp_data = 0;
    lsu_req_ready = 0; lsu_rsp_valid = 0; lsu_rsp_err = 0;
    mem_rd_en = 0; mem_wr_en = 0; gpr_wr_en = 0; csr_wr_en = 0; ebreak = 0;
    next_pc = 0; trap_vec = TRAP;
    @(posedge clk); #1;
    do_reset();

    // Straight-line addi stream, then ebreak at RESET_PC+0x10.
    for (int i = 0; i < 4; i++) do_inst(0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    chk("ebreak_pc", pc, 32'h8000_0010);
    do_inst(5, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);

    do_inst(0, 10, 0, 0, 0, 0, 0, 1'b0, 1'b0);        // long fetch-ready stall
    do_inst(2, 0, 0, 0, 0, 3, 0, 1'b0, 1'b0);         // load, 9 cycles to retire
    do_inst(2, 0, TMO - 1, 0, 1, TMO - 1, 0, 1'b0, 1'b0); // responses on last allowed cycle
    do_inst(3, 1, 2, 0, 2, 1, 0, 1'b0, 1'b0);         // store: no gpr commit
    do_inst(4, 0, 1, 0, 0, 0, 0, 1'b0, 1'b0);         // both enables -> load
    do_inst(1, 2, 0, 0, 0, 0, 0, 1'b0, 1'b0);         // csr write
    do_inst(2, 0, 0, 0, 0, 0, 2, 1'b0, 1'b0);         // lsu timeout
    do_inst(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    do_inst(0, 1, 3, 1, 0, 0, 0, 1'b0, 1'b0);         // fetch error response
    do_inst(0, 0, 0, 2, 0, 0, 0, 1'b0, 1'b0);         // fetch timeout
    do_inst(3, 0, 0, 0, 0, 2, 1, 1'b0, 1'b0);         // store error response
    do_inst(2, 0, 0, 0, 0, 5, 0, 1'b0, 1'b1);         // reset during MWAIT
    do_inst(0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int r1, r2;
      r1 = $urandom_range(0, 15);
      r2 = $urandom_range(0, 15);
      do_inst($urandom_range(0, 4), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, TMO - 1) : 0,
              (r1 == 0) ? 1 : ((r1 == 1) ? 2 : 0),
              $urandom_range(0, 3), $urandom_range(0, TMO - 1),
              (r2 == 0) ? 1 : ((r2 == 1) ? 2 : 0), 1'b0, 1'b0);
    end
    do_inst(5, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
